// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - mode codes and entry type shared by the extension stage
//
// Purpose : extension mode encodings, the {data, err} entry type and a
//           small mode-classification helper.
// Ports   : none (package).

package ext_pkg;

   localparam logic [2:0] EXT_ZEXT = 3'd0;
   localparam logic [2:0] EXT_SEXT = 3'd1;
   localparam logic [2:0] EXT_LUI  = 3'd2;
   localparam logic [2:0] EXT_LB   = 3'd3;
   localparam logic [2:0] EXT_LBU  = 3'd4;
   localparam logic [2:0] EXT_LH   = 3'd5;
   localparam logic [2:0] EXT_LHU  = 3'd6;
   localparam logic [2:0] EXT_PASS = 3'd7;

   localparam int EXT_DATA_W = 32;

   // Entry at the default datapath width; wider instances declare the same
   // shape locally at their own width.
   typedef struct packed {
      logic [EXT_DATA_W-1:0] data;
      logic                  err;
   } ext_entry_t;

   // Halfword loads are the only modes that can flag misalignment.
   function automatic logic ext_is_half(input logic [2:0] op);
      return (op == EXT_LH) || (op == EXT_LHU);
   endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// rtl/ext_pipe_if.sv - request/result handshake bundle of the extension stage
//
// Purpose : groups the request side, result side and flush of ext_pipe.
// Signals : flush, in_valid/in_ready, op, imm, mem_data, addr_lo,
//           out_valid/out_ready, out_data, out_err.
// Modports: master = producer/consumer side, slave = ext_pipe.

interface ext_pipe_if #(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int LANE_W = $clog2(DATA_W / 8)
);
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        op;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] mem_data;
   logic [LANE_W-1:0] addr_lo;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_err;

   modport master (
      output flush, in_valid, op, imm, mem_data, addr_lo, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  flush, in_valid, op, imm, mem_data, addr_lo, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate/load-data extension
//
// Purpose : computes the extended value and misalignment flag for one mode.
// Ports   : op       - mode code (ext_pkg EXT_*)
//           imm      - immediate operand
//           mem_data - aligned memory word, little-endian lanes
//           addr_lo  - byte offset within the word
//           data     - extended result
//           err      - halfword access with odd offset

module ext_core
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   parameter int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic [2:0]        op,
   input  logic [IMM_W-1:0]  imm,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [LANE_W-1:0] addr_lo,
   output logic [DATA_W-1:0] data,
   output logic              err
);

   logic [LANE_W-1:0] half_lo;
   logic [7:0]        lane_byte;
   logic [15:0]       lane_half;

   always_comb begin
      // Halfword lane ignores the low offset bit; err reports it instead.
      half_lo    = addr_lo;
      half_lo[0] = 1'b0;
      lane_byte  = mem_data[{addr_lo, 3'b000} +: 8];
      lane_half  = mem_data[{half_lo, 3'b000} +: 16];
   end

   always_comb begin
      data = '0;
      err  = ext_is_half(op) && addr_lo[0];
      case (op)
         EXT_ZEXT: data = DATA_W'(imm);
         EXT_SEXT: begin
            data = DATA_W'(imm);
            for (int i = IMM_W; i < DATA_W; i++) data[i] = imm[IMM_W-1];
         end
         EXT_LUI:  data = DATA_W'(imm) << (DATA_W - IMM_W);
         EXT_LB: begin
            data = DATA_W'(lane_byte);
            for (int i = 8; i < DATA_W; i++) data[i] = lane_byte[7];
         end
         EXT_LBU:  data = DATA_W'(lane_byte);
         EXT_LH: begin
            data = DATA_W'(lane_half);
            for (int i = 16; i < DATA_W; i++) data[i] = lane_half[15];
         end
         EXT_LHU:  data = DATA_W'(lane_half);
         EXT_PASS: data = mem_data;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered extension stage with two-entry skid buffer
//
// Purpose : accepts one extension request per cycle, holds results in a
//           main/skid pair so every output, including in_ready, is a flop.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - ext_pipe_if.slave: flush, request handshake and
//                   operands, result handshake with out_data/out_err

module ext_pipe
   import ext_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int IMM_W  = 16,
   localparam int LANE_W = $clog2(DATA_W / 8)
) (
   input  logic        clk,
   input  logic        rst_n,
   ext_pipe_if.slave   bus
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              err;
   } entry_t;

   logic [DATA_W-1:0] core_data;
   logic              core_err;
   entry_t            core_entry;
   entry_t            main_q;
   entry_t            skid_q;
   logic              main_valid;
   logic              skid_valid;
   logic              skid_valid_nx;
   logic              in_ready_q;
   logic              in_fire;
   logic              out_fire;

   ext_core #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .LANE_W (LANE_W)
   ) u_core (
      .op       (bus.op),
      .imm      (bus.imm),
      .mem_data (bus.mem_data),
      .addr_lo  (bus.addr_lo),
      .data     (core_data),
      .err      (core_err)
   );

   assign core_entry = '{data: core_data, err: core_err};
   assign in_fire    = bus.in_valid && in_ready_q;
   assign out_fire   = main_valid && bus.out_ready;

   // in_ready is the registered complement of the next skid state, so a
   // request is only ever offered a slot that is guaranteed free.
   always_comb begin
      skid_valid_nx = skid_valid;
      if (bus.flush)
         skid_valid_nx = 1'b0;
      else if (!main_valid || out_fire)
         skid_valid_nx = 1'b0;
      else if (in_fire)
         skid_valid_nx = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         skid_valid <= skid_valid_nx;
         in_ready_q <= !skid_valid_nx;
         if (bus.flush) begin
            main_valid <= 1'b0;
         end else if (!main_valid || out_fire) begin
            // Older skid entry always goes ahead of the incoming request.
            if (skid_valid) begin
               main_q     <= skid_q;
               main_valid <= 1'b1;
            end else begin
               main_valid <= in_fire;
               if (in_fire) main_q <= core_entry;
            end
         end else if (in_fire) begin
            skid_q <= core_entry;
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_q.data;
   assign bus.out_err   = main_q.err;

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - self-checking bench for ext_pipe

module tb_ext_pipe;
   import ext_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   ext_pipe_if #(.DATA_W(32), .IMM_W(16)) b ();
   ext_pipe_if #(.DATA_W(64), .IMM_W(16)) b64 ();

   ext_pipe #(.DATA_W(32), .IMM_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b)
   );

   ext_pipe #(.DATA_W(64), .IMM_W(16)) dut64 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b64)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected result from the mode definitions using plain arithmetic.
   function automatic logic [32:0] ref32(input logic [2:0] op, input logic [15:0] imm,
                                         input logic [31:0] mem, input logic [1:0] a);
      longint v;
      longint m;
      int     ai;
      logic   e;
      m  = longint'(mem);
      ai = int'(a);
      e  = 1'b0;
      v  = 0;
      case (op)
         3'd0: v = longint'(imm);
         3'd1: v = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
         3'd2: v = longint'(imm) * 65536;
         3'd3, 3'd4: begin
            v = (m / (longint'(1) << (8 * ai))) % 256;
            if (op == 3'd3 && v >= 128) v = v - 256;
         end
         3'd5, 3'd6: begin
            v = (m / (longint'(1) << (8 * (ai - ai % 2)))) % 65536;
            if (op == 3'd5 && v >= 32768) v = v - 65536;
            e = (ai % 2) == 1;
         end
         default: v = m;
      endcase
      return {e, 32'(v)};
   endfunction

   logic [32:0] q[$];

   // Model: the held results are a FIFO of at most two entries.
   always @(negedge clk) begin
      logic fire_in, fire_out;
      if (!rst_n) begin
         q.delete();
      end else begin
         check("m_out_valid", b.out_valid, q.size() != 0);
         check("m_in_ready", b.in_ready, q.size() < 2);
         if (q.size() != 0) begin
            check("m_out_data", b.out_data, q[0][31:0]);
            check("m_out_err", b.out_err, q[0][32]);
         end
         fire_in  = b.in_valid && b.in_ready;
         fire_out = b.out_valid && b.out_ready;
         if (fire_out && q.size() != 0) q.pop_front();
         if (fire_in) q.push_back(ref32(b.op, b.imm, b.mem_data, b.addr_lo));
         if (b.flush) q.delete();
      end
   end

   task automatic send1(input logic [2:0] op, input logic [15:0] imm, input logic [31:0] mem,
                        input logic [1:0] a, input logic [31:0] ed, input logic ee, input string nm);
      b.op = op; b.imm = imm; b.mem_data = mem; b.addr_lo = a;
      b.in_valid = 1'b1; b.out_ready = 1'b1;
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      check({nm, "_valid"}, b.out_valid, 1'b1);
      check({nm, "_data"}, b.out_data, ed);
      check({nm, "_err"}, b.out_err, ee);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got[$];
      logic        acc;
      int          k;

      b.flush = 0; b.in_valid = 0; b.op = 0; b.imm = 0; b.mem_data = 0; b.addr_lo = 0; b.out_ready = 0;
      b64.flush = 0; b64.in_valid = 0; b64.op = 0; b64.imm = 0; b64.mem_data = 0; b64.addr_lo = 0; b64.out_ready = 0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", b.out_valid, 1'b0);
      check("rst_out_data", b.out_data, 32'h0);
      check("rst_out_err", b.out_err, 1'b0);
      check("rst_in_ready", b.in_ready, 1'b1);
      check("rst64_out_valid", b64.out_valid, 1'b0);
      rst_n = 1'b1;

      // Single-request patterns, one-cycle latency.
      send1(EXT_SEXT, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0, "sext");
      send1(EXT_ZEXT, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0, "zext");
      send1(EXT_LB, 16'h0, 32'h80F1_7F82, 2'd2, 32'hFFFFFFF1, 1'b0, "lb2");
      send1(EXT_LBU, 16'h0, 32'h80F1_7F82, 2'd3, 32'h00000080, 1'b0, "lbu3");
      send1(EXT_LH, 16'h0, 32'h80F1_7F82, 2'd2, 32'hFFFF80F1, 1'b0, "lh2");
      send1(EXT_LHU, 16'h0, 32'h80F1_7F82, 2'd0, 32'h00007F82, 1'b0, "lhu0");
      send1(EXT_LH, 16'h0, 32'h80F1_7F82, 2'd3, 32'hFFFF80F1, 1'b1, "lh3");
      send1(EXT_LHU, 16'h0, 32'h80F1_7F82, 2'd1, 32'h00007F82, 1'b1, "lhu1");
      send1(EXT_PASS, 16'hFFFF, 32'h80F1_7F82, 2'd3, 32'h80F17F82, 1'b0, "pass");
      send1(EXT_LB, 16'h0, 32'h80F1_7F82, 2'd0, 32'hFFFFFF82, 1'b0, "lb0");

      // 64-bit instance.
      b64.op = EXT_LBU; b64.mem_data = 64'hAB00_0000_0000_0000; b64.addr_lo = 3'd7;
      b64.in_valid = 1'b1; b64.out_ready = 1'b1;
      @(posedge clk); #1;
      check("w64_lbu7", b64.out_data, 64'h0000_0000_0000_00AB);
      b64.op = EXT_SEXT; b64.imm = 16'h8001;
      @(posedge clk); #1;
      check("w64_sext", b64.out_data, 64'hFFFF_FFFF_FFFF_8001);
      b64.op = EXT_LUI; b64.imm = 16'h0001;
      @(posedge clk); #1;
      check("w64_lui", b64.out_data, 64'h0001_0000_0000_0000);
      check("w64_valid", b64.out_valid, 1'b1);
      b64.in_valid = 1'b0;

      // Back-pressure on LUI 1..4.
      @(posedge clk); #1;
      b.out_ready = 1'b0; b.op = EXT_LUI; b.imm = 16'd1; b.in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_rdy_after1", b.in_ready, 1'b1);
      b.imm = 16'd2;
      @(posedge clk); #1;
      check("bp_rdy_after2", b.in_ready, 1'b0);
      check("bp_head", b.out_data, 32'h00010000);
      b.imm = 16'd3;
      @(posedge clk); #1;
      b.out_ready = 1'b1;
      k = 3;
      got.delete();
      for (int c = 0; c < 20 && got.size() < 4; c++) begin
         @(negedge clk);
         if (b.out_valid && b.out_ready) got.push_back(b.out_data);
         acc = b.in_valid && b.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            if (k < 4) begin
               k++;
               b.imm = 16'(k);
            end else begin
               b.in_valid = 1'b0;
            end
         end
      end
      check("bp_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) check($sformatf("bp_out%0d", i), got[i], 32'(i + 1) << 16);

      // Flush with both entries full and a request presented.
      @(posedge clk); #1;
      b.out_ready = 1'b0; b.op = EXT_LUI; b.imm = 16'd5; b.in_valid = 1'b1;
      @(posedge clk); #1;
      b.imm = 16'd6;
      @(posedge clk); #1;
      check("fl_full", b.in_ready, 1'b0);
      b.imm = 16'd7; b.flush = 1'b1;
      @(posedge clk); #1;
      b.flush = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
      check("fl_out_valid", b.out_valid, 1'b0);
      check("fl_in_ready", b.in_ready, 1'b1);
      repeat (4) begin
         @(negedge clk);
         check("fl_gone", b.out_valid, 1'b0);
      end

      // Asynchronous reset mid-stream.
      @(posedge clk); #1;
      b.out_ready = 1'b0; b.op = EXT_LH; b.mem_data = 32'h80F1_7F82; b.addr_lo = 2'd3; b.in_valid = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      b.in_valid = 1'b0;
      check("ar_pre_err", b.out_err, 1'b1);
      check("ar_pre_valid", b.out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_out_valid", b.out_valid, 1'b0);
      check("ar_out_data", b.out_data, 32'h0);
      check("ar_out_err", b.out_err, 1'b0);
      check("ar_in_ready", b.in_ready, 1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      send1(EXT_ZEXT, 16'h1234, 32'h0, 2'd0, 32'h00001234, 1'b0, "post_rst");

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
